// File: rtl/alu_shift_arbiter.sv
// Two-requester round-robin arbiter in front of a shared shift/rotate unit.
// The granted operation is computed combinationally and captured in a
// single-entry result buffer that drains through a valid/ready handshake.
module alu_shift_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_id,
  output logic             out_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state;
  logic               ptr;
  logic               can_accept;
  logic               grant0;
  logic               grant1;
  logic               grant;
  logic [WIDTH-1:0]   sel_a;
  logic [2:0]         sel_op;
  logic [4:0]         sh;
  logic [WIDTH-1:0]   shift_res;
  logic               shift_err;
  logic [2*WIDTH-1:0] rotl_tmp;
  logic [2*WIDTH-1:0] rotr_tmp;
  logic               unused_b;

  // Only the low five bits of B form the shift amount.
  assign unused_b = ^{req0_b[WIDTH-1:5], req1_b[WIDTH-1:5]};

  assign out_valid = (state == FULL);

  // rst_n is folded in so no ready can be seen while reset is held.
  assign can_accept = rst_n & en & ((state == EMPTY) | (out_valid & out_ready));

  // Lone requester wins outright; on contention the pointer decides.
  assign grant0 = can_accept & req0_valid & (~req1_valid | ~ptr);
  assign grant1 = can_accept & req1_valid & (~req0_valid | ptr);
  assign grant  = grant0 | grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_a  = grant1 ? req1_a : req0_a;
  assign sel_op = grant1 ? req1_op : req0_op;
  assign sh     = grant1 ? req1_b[4:0] : req0_b[4:0];

  // Shared shift datapath; rotates use a doubled operand so sh=0 needs no special case.
  always_comb begin
    shift_res = '0;
    shift_err = 1'b0;
    rotl_tmp  = {sel_a, sel_a} << sh;
    rotr_tmp  = {sel_a, sel_a} >> sh;
    case (sel_op)
      3'b001:  shift_res = sel_a << sh;
      3'b010:  shift_res = $signed(sel_a) >>> sh;
      3'b011:  shift_res = rotl_tmp[2*WIDTH-1:WIDTH];
      3'b100:  shift_res = rotr_tmp[WIDTH-1:0];
      default: shift_err = 1'b1;
    endcase
  end

  // Result buffer FSM, output registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ptr        <= 1'b0;
      out_result <= '0;
      out_id     <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (grant) begin
        state      <= FULL;
        ptr        <= grant0;
        out_result <= shift_res;
        out_id     <= grant1;
        out_err    <= shift_err;
      end else if (state == FULL && out_ready) begin
        state      <= EMPTY;
        out_result <= '0;
        out_id     <= 1'b0;
        out_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_shift_arbiter.sv
// Directed bench for alu_shift_arbiter: stimulus pushes expected results into
// a scoreboard queue, an independent monitor pops and compares on each drain.
module tb_alu_shift_arbiter;

  localparam logic [2:0] OP_BAD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SAR  = 3'b010;
  localparam logic [2:0] OP_ROTL = 3'b011;
  localparam logic [2:0] OP_ROTR = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_id, out_err;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors    = 0;
  int   checks    = 0;
  int   pushed    = 0;
  int   popped    = 0;
  int   discarded = 0;

  always #5 clk = ~clk;

  alu_shift_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_id     (out_id),
    .out_err    (out_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] res, input logic err);
    exp_t t;
    t.id  = id;
    t.err = err;
    t.res = res;
    sb.push_back(t);
    pushed++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one request alone and wait (bounded) for its grant.
  task automatic issue(input logic idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] exp_res, input logic exp_err);
    bit got;
    got = 1'b0;
    if (idx == 1'b0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((idx == 1'b0 && req0_ready) || (idx == 1'b1 && req1_ready)) got = 1'b1;
    end
    chk("issue_grant_in_budget", 32'(got), 32'd1);
    if (got) push(idx, exp_res, exp_err);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Scoreboard monitor: every result accepted by the consumer is compared.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id=%0d res=0x%08h expected no result", out_id, out_result);
      end else begin
        mon_e = sb.pop_front();
        popped++;
        chk("mon_result", out_result, mon_e.res);
        chk("mon_id", 32'(out_id), 32'(mon_e.id));
        chk("mon_err", 32'(out_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k0, k1;
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // SLL 1<<4 with one-cycle latency, then zeroed outputs once empty
    out_ready = 1'b1;
    req0_a = 32'h1; req0_b = 32'd4; req0_op = OP_SLL; req0_valid = 1'b1;
    @(negedge clk);
    chk("sll_ready0", 32'(req0_ready), 32'd1);
    chk("sll_ready1", 32'(req1_ready), 32'd0);
    push(1'b0, 32'h0000_0010, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("sll_latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_result_zero", out_result, 32'd0);

    // Fresh reset, both valid: requester 0 first, then 1
    rst_n = 1'b0; #2; rst_n = 1'b1;
    req0_a = 32'h8000_0000; req0_b = 32'd31; req0_op = OP_SAR;  req0_valid = 1'b1;
    req1_a = 32'h0000_0001; req1_b = 32'd1;  req1_op = OP_ROTR; req1_valid = 1'b1;
    @(negedge clk);
    chk("both_first_ready0", 32'(req0_ready), 32'd1);
    chk("both_first_ready1", 32'(req1_ready), 32'd0);
    push(1'b0, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("both_second_ready1", 32'(req1_ready), 32'd1);
    push(1'b1, 32'h8000_0000, 1'b0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    idle(2);

    // Stall while FULL, then drain and grant on the same edge
    out_ready = 1'b0;
    issue(1'b0, 32'h3, 32'd1, OP_SLL, 32'h6, 1'b0);
    req0_a = 32'h1234_5678; req0_b = 32'd32; req0_op = OP_ROTL; req0_valid = 1'b1;
    req1_a = 32'hDEAD_BEEF; req1_b = 32'd7;  req1_op = OP_BAD;  req1_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready0", 32'(req0_ready), 32'd0);
      chk("stall_ready1", 32'(req1_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", out_result, 32'h6);
      chk("stall_id", 32'(out_id), 32'd0);
      chk("stall_err", 32'(out_err), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_grant_ready1", 32'(req1_ready), 32'd1);
    chk("drain_grant_ready0", 32'(req0_ready), 32'd0);
    push(1'b1, 32'h0, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("drain_grant_valid", 32'(out_valid), 32'd1);
    chk("illegal_op_err", 32'(out_err), 32'd1);
    @(negedge clk);
    chk("rotl32_ready0", 32'(req0_ready), 32'd1);
    push(1'b0, 32'h1234_5678, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    idle(2);

    // Global enable low blocks grants
    en = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("en0_ready0", 32'(req0_ready), 32'd0);
      chk("en0_ready1", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    en = 1'b1;

    // Reset while a result is held, pointer left favouring requester 1
    issue(1'b1, 32'h1, 32'd3, OP_SLL, 32'h8, 1'b0);
    idle(2);
    out_ready = 1'b0;
    issue(1'b0, 32'h5, 32'd2, OP_SLL, 32'd20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_result", out_result, 32'd0);
    chk("async_rst_err", 32'(out_err), 32'd0);
    discarded += sb.size();
    sb.delete();
    out_ready = 1'b1;
    req0_a = 32'h7FFF_FFF0; req0_b = 32'd4;  req0_op = OP_SAR; req0_valid = 1'b1;
    req1_a = 32'hFFFF_FFFF; req1_b = 32'd31; req1_op = OP_SLL; req1_valid = 1'b1;
    @(negedge clk);
    chk("in_rst_ready0", 32'(req0_ready), 32'd0);
    chk("in_rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_rst_no_grant", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready0", 32'(req0_ready), 32'd1);
    chk("post_rst_ready1", 32'(req1_ready), 32'd0);
    push(1'b0, 32'h07FF_FFFF, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_second_ready1", 32'(req1_ready), 32'd1);
    push(1'b1, 32'h8000_0000, 1'b0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    idle(2);

    // Continuous contention: alternating grants, one result per cycle
    k0 = 0; k1 = 0;
    out_ready = 1'b1;
    req0_a = 32'(k0 + 1); req0_b = 32'(k0); req0_op = OP_SLL; req0_valid = 1'b1;
    req1_a = 32'h8000_0000 | 32'(k1); req1_b = 32'hFFFF_FFE1; req1_op = OP_ROTL; req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) chk("stream_valid", 32'(out_valid), 32'd1);
      if (i % 2 == 0) begin
        chk("stream_ready0", 32'(req0_ready), 32'd1);
        chk("stream_ready1_idle", 32'(req1_ready), 32'd0);
        push(1'b0, 32'(k0 + 1) << k0, 1'b0);
      end else begin
        chk("stream_ready1", 32'(req1_ready), 32'd1);
        chk("stream_ready0_idle", 32'(req0_ready), 32'd0);
        push(1'b1, (32'(k1) << 1) | 32'h1, 1'b0);
      end
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        k0++;
        req0_a = 32'(k0 + 1); req0_b = 32'(k0);
      end else begin
        k1++;
        req1_a = 32'h8000_0000 | 32'(k1);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle(3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("pop_count", 32'(popped), 32'(pushed - discarded));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_shift_arbiter.md
ALU_SHIFT_ARBITER -- requirements
Module: alu_shift_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of operands and result (fixed at 32 for this release).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  global enable; 0 blocks new grants, output drain continues.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  requester's operation accepted this cycle.
REQ-007 SHALL have ports req0_a / req1_a  input  32  operand A, value shifted.
REQ-008 SHALL have ports req0_b / req1_b  input  32  operand B, shift amount source.
REQ-009 SHALL have ports req0_op / req1_op  input  3  opcode: 001 SLL, 010 SAR, 011 ROTL, 100 ROTR.
REQ-010 SHALL have port out_valid  output  1  result buffer holds a result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_result  output  32  shifted result.
REQ-013 SHALL have port out_id  output  1  requester index (0/1) of out_result.
REQ-014 SHALL have port out_err  output  1  opcode of out_result was illegal.

Function
REQ-015 SHALL share one shift datapath between two requesters; transfer occurs when reqN_valid & reqN_ready are high at a rising edge.
REQ-016 SHALL use shift amount sh = B[4:0]; B[31:5] ignored.
REQ-017 SHALL compute SLL = A << sh; SAR = arithmetic right by sh (sign fill); ROTL/ROTR = rotate by sh, sh=0 returns A unchanged.
REQ-018 SHALL produce result 0 with out_err=1 for opcodes 000, 101, 110, 111; out_err=0 otherwise.
REQ-019 SHALL hold a single-entry result buffer with states EMPTY and FULL.
REQ-020 SHALL define can_accept = en & (EMPTY | (out_valid & out_ready)).
REQ-021 SHALL assert at most one reqN_ready per cycle, only when can_accept and reqN_valid; ready is combinational from valid, state, pointer.
REQ-022 SHALL arbitrate round-robin: priority pointer selects favoured requester; if only one valid, it is granted regardless of pointer.
REQ-023 SHALL move pointer to the other requester after every grant; pointer unchanged when no grant.
REQ-024 SHALL register result, id, err at the accepting edge; out_valid rises the cycle after acceptance (latency 1).
REQ-025 SHALL transition EMPTY->FULL on grant; FULL->EMPTY on out_ready without grant; FULL->FULL on drain+grant same cycle (throughput 1 op/cycle).
REQ-026 SHALL keep out_result, out_id, out_err stable while out_valid=1 and out_ready=0.
REQ-027 SHALL not require reqN_valid to stay high without ready; no request is stored before grant.
REQ-028 SHALL drive out_result/out_id/out_err to 0 whenever EMPTY.

Reset
REQ-029 SHALL on rst_n=0 immediately force state EMPTY, out_valid=0, out_result=0, out_id=0, out_err=0, pointer=requester 0.
REQ-030 SHALL discard any buffered result on reset mid-operation; no grant occurs while rst_n=0.
REQ-031 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL cover: req0 SLL A=0x00000001 B=4, out_ready=1 -> next cycle out_valid=1, out_result=0x00000010, out_id=0, out_err=0.
REQ-033 SHALL cover: after reset both valid, req0 SAR A=0x80000000 B=31, req1 ROTR A=0x00000001 B=1 -> first 0xFFFFFFFF id0, next cycle 0x80000000 id1.
REQ-034 SHALL cover: FULL with out_ready=0 for 3 cycles, both requesters valid -> both ready=0, outputs stable; out_ready=1 -> drain and new grant same edge.
REQ-035 SHALL cover: ROTL A=0x12345678 B=32 -> 0x12345678; opcode 000 -> out_result=0, out_err=1; en=0 -> no ready.
REQ-036 SHALL cover: rst_n low while out_valid=1 -> out_valid=0 without clock edge; after release, both valid -> req0 granted first.
REQ-037 SHALL cover: both valid continuously with out_ready=1 for 8 cycles -> grants alternate 0,1,0,1..., one result per cycle, no loss or duplication.
